// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, registered ALU-side values out.
// The master drives the ID side; the slave is the pipeline register.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             stall;
  logic             flush;
  logic             inValid;
  logic [1:0]       aluOp;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic [15:0]      imm;
  logic             aluSrc;
  logic [4:0]       rtAddr;
  logic [4:0]       rdAddr;
  logic             regDst;
  logic             regWriteIn;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic [WIDTH-1:0] exMemData;
  logic [WIDTH-1:0] memWbData;

  logic [3:0]       aluCode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] storeData;
  logic [4:0]       writeReg;
  logic             regWrite;
  logic             outValid;
  logic             aluErr;
  logic [CNT_W-1:0] illegalCount;

  modport master (
    output stall, flush, inValid, aluOp, funct, rsData, rtData, imm, aluSrc,
           rtAddr, rdAddr, regDst, regWriteIn, fwdA, fwdB, exMemData, memWbData,
    input  aluCode, a, b, storeData, writeReg, regWrite, outValid, aluErr, illegalCount
  );

  modport slave (
    input  stall, flush, inValid, aluOp, funct, rsData, rtData, imm, aluSrc,
           rtAddr, rdAddr, regDst, regWriteIn, fwdA, fwdB, exMemData, memWbData,
    output aluCode, a, b, storeData, writeReg, regWrite, outValid, aluErr, illegalCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding/immediate select,
// stall/flush handling and a saturating count of illegal ALU encodings.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_stage_if.slave   bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = ALU_ILL;
    case (op)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b10: begin
        case (fn)
          6'b100000: code = ALU_ADD;
          6'b100010: code = ALU_SUB;
          6'b100100: code = ALU_AND;
          6'b100101: code = ALU_OR;
          6'b101010: code = ALU_SLT;
          default:   code = ALU_ILL;
        endcase
      end
      default: code = ALU_ILL;
    endcase
    return code;
  endfunction

  // 11 is reserved and falls back to the register-file value.
  function automatic logic signed [WIDTH-1:0] fwd_sel(
    input logic [1:0]              sel,
    input logic signed [WIDTH-1:0] rf,
    input logic signed [WIDTH-1:0] exm,
    input logic signed [WIDTH-1:0] mwb
  );
    logic signed [WIDTH-1:0] r;
    case (sel)
      2'b01:   r = mwb;
      2'b10:   r = exm;
      default: r = rf;
    endcase
    return r;
  endfunction

  function automatic logic signed [WIDTH-1:0] sign_ext(input logic [15:0] v);
    return {{(WIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // p0: combinational decode and operand selection ahead of the register
  logic [3:0]              code_p0;
  logic                    illegal_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] rt_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [4:0]              wr_p0;
  logic                    rw_p0;

  assign code_p0    = alu_decode(bus.aluOp, bus.funct);
  assign illegal_p0 = (code_p0 == ALU_ILL);
  assign a_p0       = fwd_sel(bus.fwdA, bus.rsData, bus.exMemData, bus.memWbData);
  assign rt_p0      = fwd_sel(bus.fwdB, bus.rtData, bus.exMemData, bus.memWbData);
  assign b_p0       = bus.aluSrc ? sign_ext(bus.imm) : rt_p0;
  assign wr_p0      = bus.regDst ? bus.rdAddr : bus.rtAddr;
  assign rw_p0      = bus.regWriteIn & bus.inValid & ~illegal_p0;

  // p1: registered values presented to the ALU
  logic [3:0]              code_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic signed [WIDTH-1:0] sd_p1;
  logic [4:0]              wr_p1;
  logic                    rw_p1;
  logic                    vld_p1;
  logic                    err_p1;
  logic [CNT_W-1:0]        cnt_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_p1 <= ALU_ADD;
      a_p1    <= '0;
      b_p1    <= '0;
      sd_p1   <= '0;
      wr_p1   <= '0;
      rw_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (bus.flush) begin
      // Bubble wins over a simultaneous stall; the counter is untouched.
      code_p1 <= ALU_ADD;
      a_p1    <= '0;
      b_p1    <= '0;
      sd_p1   <= '0;
      wr_p1   <= '0;
      rw_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else if (!bus.stall) begin
      code_p1 <= code_p0;
      a_p1    <= a_p0;
      b_p1    <= b_p0;
      sd_p1   <= rt_p0;
      wr_p1   <= wr_p0;
      rw_p1   <= rw_p0;
      vld_p1  <= bus.inValid;
      err_p1  <= illegal_p0;
      if (bus.inValid && illegal_p0)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.aluCode      = code_p1;
  assign bus.a            = a_p1;
  assign bus.b            = b_p1;
  assign bus.storeData    = sd_p1;
  assign bus.writeReg     = wr_p1;
  assign bus.regWrite     = rw_p1;
  assign bus.outValid     = vld_p1;
  assign bus.aluErr       = err_p1;
  assign bus.illegalCount = cnt_p1;

endmodule
